// File: rtl/sm4_round_ctrl.sv
// rtl/sm4_round_ctrl.sv - SM4 round sequencer: accept, iterate ROUNDS rounds, hold result until consumed
`timescale 1ns/1ps

module sm4_round_ctrl #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic         decrypt,
  input  logic         abort,
  output logic [5:0]   sm4_enc,
  output logic [4:0]   rk_index,
  output logic         round_en,
  input  logic [127:0] round_result,
  output logic [127:0] data_out,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_t       state_q,    state_d;
  logic [5:0]   sm4_enc_q,  sm4_enc_d;
  logic         decrypt_q,  decrypt_d;
  logic [127:0] data_out_q, data_out_d;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q    <= IDLE;
      sm4_enc_q  <= '0;
      decrypt_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      sm4_enc_q  <= sm4_enc_d;
      decrypt_q  <= decrypt_d;
      data_out_q <= data_out_d;
    end
  end

  // Abort overrides everything, including an accept from IDLE.
  always_comb begin
    state_d    = state_q;
    sm4_enc_d  = sm4_enc_q;
    decrypt_d  = decrypt_q;
    data_out_d = data_out_q;
    if (abort) begin
      state_d   = IDLE;
      sm4_enc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_d   = RUN;
            sm4_enc_d = '0;
            decrypt_d = decrypt;
          end
        end
        RUN: begin
          if (sm4_enc_q == LAST_RND) begin
            // Final SM4 reverse transform: word order swapped end-for-end.
            data_out_d = {round_result[31:0],  round_result[63:32],
                          round_result[95:64], round_result[127:96]};
            sm4_enc_d  = '0;
            state_d    = DONE;
          end else begin
            sm4_enc_d = sm4_enc_q + 6'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          sm4_enc_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    round_en    = (state_q == RUN);
    out_valid   = (state_q == DONE);
    sm4_enc     = sm4_enc_q;
    data_out    = data_out_q;
    // Decryption walks the key schedule backwards.
    rk_index    = decrypt_q ? 5'(LAST_RND - sm4_enc_q) : sm4_enc_q[4:0];
  end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// tb/tb_sm4_round_ctrl.sv - scoreboard bench for sm4_round_ctrl with a behavioural SM4 round datapath
`timescale 1ns/1ps

module tb_sm4_round_ctrl;

  localparam int ROUNDS = 32;
  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk = 1'b0;
  logic         rest = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         decrypt = 1'b0;
  logic         abort = 1'b0;
  logic [5:0]   sm4_enc;
  logic [4:0]   rk_index;
  logic         round_en;
  logic [127:0] round_result;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready = 1'b0;

  sm4_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rest(rest), .start_valid(start_valid), .start_ready(start_ready),
    .decrypt(decrypt), .abort(abort), .sm4_enc(sm4_enc), .rk_index(rk_index),
    .round_en(round_en), .round_result(round_result), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // SM4 S-box, one 16-byte row per entry
  logic [127:0] sbox_rows [0:15] = '{
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    int idx;
    row = sbox_rows[b[7:4]];
    idx = 15 - int'(b[3:0]);
    return row[8*idx +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(a[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] lin(input logic [31:0] b);
    return b ^ rl(b, 2) ^ rl(b, 10) ^ rl(b, 18) ^ rl(b, 24);
  endfunction

  function automatic logic [31:0] lin_k(input logic [31:0] b);
    return b ^ rl(b, 13) ^ rl(b, 23);
  endfunction

  logic [31:0]  rk [0:31];
  logic [127:0] pt = '0;
  logic [127:0] st = '0;

  task automatic expand_key();
    logic [31:0] k [0:35];
    logic [31:0] fk [0:3];
    logic [31:0] ck;
    fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
    for (int i = 0; i < 4; i++) k[i] = KEY[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      k[i+4] = k[i] ^ lin_k(tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck));
      rk[i]  = k[i+4];
    end
  endtask

  // Round datapath: sm4_enc==0 selects the fresh block, otherwise the running state
  always_comb begin
    logic [127:0] x;
    logic [31:0]  x4;
    x  = (sm4_enc == 6'd0) ? pt : st;
    x4 = x[127:96] ^ lin(tau(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk[rk_index]));
    round_result = {x[95:0], x4};
  end

  always @(posedge clk) if (round_en) st <= round_result;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor state
  logic         prev_ov = 1'b0;
  logic [127:0] held = '0;
  logic         dec_tb = 1'b0;
  logic         b2b_mode = 1'b0;
  logic         have_hs = 1'b0;
  int           run_idx = 0;
  int           last_accept = 0;
  int           last_hs = 0;
  int           accept_cnt = 0;
  int           out_cnt = 0;

  always @(negedge clk) begin
    if (rest) begin
      if (round_en) begin
        chk("sm4_enc_seq", 128'(sm4_enc), 128'(run_idx));
        chk("rk_index_seq", 128'(rk_index), 128'(dec_tb ? (ROUNDS - 1 - run_idx) : run_idx));
        run_idx++;
      end
      if (out_valid && !prev_ov) begin
        chk("latency", 128'(cyc - last_accept), 128'(ROUNDS));
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out: got out_valid with data %0h, expected no output", data_out);
        end else begin
          chk("data_out", data_out, exp_q.pop_front());
        end
        held = data_out;
        out_cnt++;
      end else if (out_valid) begin
        chk("data_hold", data_out, held);
      end
      if (out_valid && out_ready) begin
        last_hs = cyc + 1;
        have_hs = 1'b1;
      end
      if (start_valid && start_ready && !abort) begin
        if (b2b_mode && have_hs) chk("b2b_gap", 128'(cyc + 1 - last_hs), 128'(1));
        last_accept = cyc + 1;
        run_idx     = 0;
        dec_tb      = decrypt;
        accept_cnt++;
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [127:0] p, input logic d, input logic [127:0] e, input logic push);
    pt = p;
    decrypt = d;
    if (push) exp_q.push_back(e);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_outs(input int target);
    int k = 0;
    while (out_cnt < target && k < 200) begin
      tick();
      k++;
    end
    if (out_cnt < target) begin
      n_chk++;
      $display("FAIL wait_out: got %0d outputs expected %0d", out_cnt, target);
    end
  endtask

  task automatic wait_enc(input logic [5:0] v);
    int k = 0;
    while (sm4_enc != v && k < 100) begin
      tick();
      k++;
    end
    chk("wait_enc", 128'(sm4_enc), 128'(v));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int a0;
    int k;
    expand_key();
    #12;
    chk("rst_start_ready", 128'(start_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_round_en", 128'(round_en), 128'(0));
    chk("rst_sm4_enc", 128'(sm4_enc), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    tick();
    rest = 1'b1;
    tick();

    // Encrypt then decrypt known-answer vectors
    issue(PT, 1'b0, CT, 1'b1);
    wait_outs(1);
    handshake();
    issue(CT, 1'b1, PT, 1'b1);
    wait_outs(2);
    handshake();

    // Back-pressure with a stray request in DONE
    issue(PT, 1'b0, CT, 1'b1);
    wait_outs(3);
    start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_start_ready", 128'(start_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      tick();
    end
    start_valid = 1'b0;
    handshake();
    chk("bp_release_ov", 128'(out_valid), 128'(0));
    chk("bp_release_ready", 128'(start_ready), 128'(1));

    // Abort in IDLE blocks the accept
    abort = 1'b1;
    start_valid = 1'b1;
    tick();
    abort = 1'b0;
    start_valid = 1'b0;
    chk("idle_abort_ready", 128'(start_ready), 128'(1));
    chk("idle_abort_run", 128'(round_en), 128'(0));

    // Abort mid-run
    issue(PT, 1'b0, '0, 1'b0);
    wait_enc(6'd15);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_sm4_enc", 128'(sm4_enc), 128'(0));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_round_en", 128'(round_en), 128'(0));
    chk("abort_data_kept", data_out, CT);
    issue(PT, 1'b0, CT, 1'b1);
    wait_outs(4);
    handshake();

    // Asynchronous reset mid-run, then immediate new request
    issue(PT, 1'b0, '0, 1'b0);
    wait_enc(6'd20);
    #2 rest = 1'b0;
    #1;
    chk("arst_start_ready", 128'(start_ready), 128'(1));
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_round_en", 128'(round_en), 128'(0));
    chk("arst_sm4_enc", 128'(sm4_enc), 128'(0));
    chk("arst_data_out", data_out, 128'(0));
    @(posedge clk);
    #1;
    rest = 1'b1;
    issue(CT, 1'b1, PT, 1'b1);
    chk("arst_first_accept", 128'(round_en), 128'(1));
    wait_outs(5);
    handshake();

    // start_valid held: back-to-back blocks
    b2b_mode = 1'b1;
    have_hs  = 1'b0;
    a0 = accept_cnt;
    pt = PT;
    decrypt = 1'b0;
    exp_q.push_back(CT);
    exp_q.push_back(CT);
    out_ready = 1'b1;
    start_valid = 1'b1;
    k = 0;
    while (accept_cnt < a0 + 2 && k < 200) begin
      tick();
      k++;
    end
    start_valid = 1'b0;
    chk("b2b_accepts", 128'(accept_cnt - a0), 128'(2));
    wait_outs(7);
    tick();
    out_ready = 1'b0;
    b2b_mode = 1'b0;

    repeat (5) tick();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
